// File: rtl/keccak_pkg.sv
// Shared Keccak definitions for the slice-serial rho stage: geometry,
// rho offset table (index 5*y+x) and the stage state encoding.
package keccak_pkg;

   localparam int COUNT_DEFAULT = 64;
   localparam int SLICE_W       = 25;

   localparam int RHO_OFF [SLICE_W] = '{
       0,  1, 62, 28, 27,
      36, 44,  6, 55, 20,
       3, 10, 43, 25, 39,
      41, 45, 15, 21,  8,
      18,  2, 61, 56, 14
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Source slice for a lane: (cnt - r) mod count, kept non-negative before the modulo.
   function automatic int rho_src(input int cnt, input int lane, input int count);
      int off;
      off = RHO_OFF[lane] % count;
      return (cnt + count - off) % count;
   endfunction

endpackage

// File: rtl/rho_slice_buffer.sv
// Count x 25 slice register file: one slice-wide write port and one
// independent read address per lane, so a whole rotated slice reads out at once.
module rho_slice_buffer
   import keccak_pkg::*;
#(
   parameter  int Count   = COUNT_DEFAULT,
   localparam int CntBits = $clog2(Count)
) (
   input  logic                             clk,
   input  logic                             wr_en,
   input  logic [CntBits-1:0]               wr_idx,
   input  logic [SLICE_W-1:0]               wr_data,
   input  logic [SLICE_W-1:0][CntBits-1:0]  rd_idx,
   output logic [SLICE_W-1:0]               rd_data
);

   logic [Count-1:0][SLICE_W-1:0] slice_q;
   logic [Count-1:0][SLICE_W-1:0] slice_d;

   always_comb begin
      slice_d = slice_q;
      for (int i = 0; i < Count; i++) begin
         if (wr_en && (wr_idx == CntBits'(i))) begin
            slice_d[i] = wr_data;
         end
      end
   end

   // Contents are don't-care after reset; every slice is rewritten before use.
   always_ff @(posedge clk) begin
      slice_q <= slice_d;
   end

   generate
      for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_lane_rd
         assign rd_data[gi] = slice_q[rd_idx[gi]][gi];
      end
   endgenerate

endmodule

// File: rtl/rho_slice_stage.sv
// Keccak rho on a slice-serial stream: buffers Count input slices, then
// emits Count slices where each lane is read from its rotated source slice.
module rho_slice_stage
   import keccak_pkg::*;
#(
   parameter int Count = COUNT_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               inValid,
   input  logic [SLICE_W-1:0] matrixIn,
   output logic               inReady,
   output logic [SLICE_W-1:0] matrixOut,
   output logic               outValid,
   input  logic               outReady,
   output logic               busy,
   output logic               done
);

   localparam int                CntBits = $clog2(Count);
   localparam logic [CntBits-1:0] LastIdx = CntBits'(Count - 1);

   state_t             state_q, state_d;
   logic [CntBits-1:0] in_cnt_q, in_cnt_d;
   logic [CntBits-1:0] out_cnt_q, out_cnt_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wr_en;

   logic [SLICE_W-1:0][CntBits-1:0] rd_idx;
   logic [SLICE_W-1:0]              rot_slice;

   generate
      for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_rd_idx
         assign rd_idx[gi] = CntBits'(rho_src(int'(out_cnt_q), gi, Count));
      end
   endgenerate

   rho_slice_buffer #(.Count(Count)) u_buffer (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (in_cnt_q),
      .wr_data (matrixIn),
      .rd_idx  (rd_idx),
      .rd_data (rot_slice)
   );

   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      wr_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_LOAD;
               in_cnt_d = '0;
            end
         end
         ST_LOAD: begin
            if (inValid) begin
               wr_en    = 1'b1;
               in_cnt_d = in_cnt_q + 1'b1;
               if (in_cnt_q == LastIdx) begin
                  state_d   = ST_EMIT;
                  out_cnt_d = '0;
               end
            end
         end
         ST_EMIT: begin
            if (outReady) begin
               out_cnt_d = out_cnt_q + 1'b1;
               if (out_cnt_q == LastIdx) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Handshake outputs are registered images of the next state.
      in_ready_d  = (state_d == ST_LOAD);
      out_valid_d = (state_d == ST_EMIT);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign inReady   = in_ready_q;
   assign outValid  = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   // Buffer is uninitialised, so the slice is forced to zero whenever it is not valid.
   assign matrixOut = out_valid_q ? rot_slice : '0;

endmodule

// File: tb/tb_rho_slice_stage.sv
// Directed bench for rho_slice_stage with a lane-rotation reference model.
module tb_rho_slice_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        inValid;
   logic [24:0] matrixIn;
   logic        inReady;
   logic [24:0] matrixOut;
   logic        outValid;
   logic        outReady;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   rho_slice_stage #(.Count(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .inValid   (inValid),
      .matrixIn  (matrixIn),
      .inReady   (inReady),
      .matrixOut (matrixOut),
      .outValid  (outValid),
      .outReady  (outReady),
      .busy      (busy),
      .done      (done)
   );

   int checks = 0;
   int errors = 0;

   logic [63:0] in_lane   [5][5];
   logic [24:0] exp_slice [64];
   logic [24:0] dut_out   [64];
   int          exp_idx = 0;
   int          done_cnt = 0;

   // Rotation amounts indexed [x][y].
   int r_tab [5][5] = '{
      '{ 0, 36,  3, 41, 18},
      '{ 1, 44, 10, 45,  2},
      '{62,  6, 43, 15, 61},
      '{28, 55, 25, 21, 56},
      '{27, 20, 39,  8, 14}
   };

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [63:0] rotl(input logic [63:0] v, input int s);
      if (s == 0) return v;
      return (v << s) | (v >> (64 - s));
   endfunction

   function automatic logic [24:0] in_slice(input int z);
      logic [24:0] s;
      s = '0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            s[5*y+x] = in_lane[x][y][z];
      return s;
   endfunction

   task automatic build_expected();
      logic [63:0] rot;
      for (int z = 0; z < 64; z++) begin
         exp_slice[z] = '0;
         dut_out[z]   = '0;
      end
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++) begin
            rot = rotl(in_lane[x][y], r_tab[x][y]);
            for (int z = 0; z < 64; z++) exp_slice[z][5*y+x] = rot[z];
         end
   endtask

   task automatic clear_lanes();
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++) in_lane[x][y] = '0;
   endtask

   task automatic random_lanes();
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++) in_lane[x][y] = {$urandom, $urandom};
   endtask

   // Called at posedge+1; returns at posedge+1 after the n-th slice is accepted.
   task automatic send_slices(input int n, input int gaps, input int noisy);
      for (int z = 0; z < n; z++) begin
         if (gaps != 0 && $urandom_range(0, 3) == 0) begin
            inValid  = 1'b0;
            matrixIn = 25'($urandom);
            @(posedge clk); #1;
         end
         inValid  = 1'b1;
         matrixIn = in_slice(z);
         start    = (noisy != 0 && z == 10);
         @(negedge clk);
         chk($sformatf("inready_load_z%0d", z), inReady, 1);
         chk($sformatf("busy_load_z%0d", z), busy, 1);
         @(posedge clk); #1;
      end
      inValid  = 1'b0;
      start    = 1'b0;
      matrixIn = '0;
   endtask

   task automatic drain(input int pat, input int noisy);
      int  cyc;
      logic seen;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 400) begin
         outReady = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (noisy != 0) begin
            start    = 1'($urandom_range(0, 1));
            inValid  = 1'b1;
            matrixIn = 25'($urandom);
         end
         @(negedge clk);
         if (done) seen = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      outReady = 1'b0;
      start    = 1'b0;
      inValid  = 1'b0;
      matrixIn = '0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got no done, expected done within 400 cycles");
      end
   endtask

   task automatic run(input int gaps, input int pat, input int noisy);
      build_expected();
      exp_idx  = 0;
      done_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send_slices(64, gaps, noisy);
      @(negedge clk);
      chk("first_out_latency", outValid, 1);
      @(posedge clk); #1;
      drain(pat, noisy);
      chk("done_count", done_cnt, 1);
      chk("slices_seen", exp_idx, 64);
   endtask

   // Compare process: checks every transfer against the model, hold stability, and done/busy.
   initial begin : monitor
      logic        hold;
      logic [24:0] held;
      logic        prev_done;
      hold      = 1'b0;
      held      = '0;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold      = 1'b0;
            prev_done = 1'b0;
         end else begin
            if (hold) begin
               chk("hold_valid", outValid, 1);
               chk("hold_data", matrixOut, held);
            end
            if (outValid) begin
               chk("inready_in_emit", inReady, 0);
               if (outReady) begin
                  if (exp_idx < 64) begin
                     chk($sformatf("slice%0d", exp_idx), matrixOut, exp_slice[exp_idx]);
                     dut_out[exp_idx] = matrixOut;
                  end else begin
                     checks++;
                     errors++;
                     $display("FAIL extra_transfer: got transfer %0d, expected at most 64", exp_idx + 1);
                  end
                  exp_idx++;
               end
            end
            hold = outValid && !outReady;
            held = matrixOut;
            if (prev_done) begin
               chk("done_one_cycle", done, 0);
               chk("busy_after_done", busy, 0);
            end
            if (done) begin
               done_cnt++;
               chk("done_after_last", exp_idx, 64);
               chk("busy_with_done", busy, 1);
            end
            prev_done = done;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst      = 1'b1;
      start    = 1'b0;
      inValid  = 1'b0;
      matrixIn = '0;
      outReady = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_inready", inReady, 0);
      chk("reset_outvalid", outValid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_matrixout", matrixOut, 0);
      @(posedge clk); #1;

      // Single bit in lane (1,0) at slice 0.
      clear_lanes();
      in_lane[1][0][0] = 1'b1;
      run(0, 0, 0);
      chk("t1_model_slice1", exp_slice[1], 25'h0000002);
      chk("t1_dut_slice1", dut_out[1], 25'h0000002);
      chk("t1_dut_slice0", dut_out[0], 25'h0000000);
      chk("t1_dut_slice2", dut_out[2], 25'h0000000);

      // Wrap-around: lane (2,0) slice 5 lands at slice 3; lane (0,0) all ones.
      clear_lanes();
      in_lane[2][0][5] = 1'b1;
      in_lane[0][0]    = '1;
      run(0, 0, 0);
      chk("t2_model_slice3", exp_slice[3], 25'h0000005);
      chk("t2_dut_slice3", dut_out[3], 25'h0000005);
      chk("t2_dut_slice0", dut_out[0], 25'h0000001);
      chk("t2_dut_slice63", dut_out[63], 25'h0000001);

      // Random state with input gaps.
      random_lanes();
      run(1, 0, 0);

      // Back-pressure pattern 1,0,0,1.
      random_lanes();
      run(0, 1, 0);

      // Abort after 30 slices, then a full new state.
      random_lanes();
      done_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send_slices(30, 0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_inready", inReady, 0);
      chk("abort_outvalid", outValid, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      random_lanes();
      run(1, 0, 0);

      // start and inValid noise during LOAD and EMIT.
      random_lanes();
      run(1, 0, 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rho_slice_stage.md
Name: rho_slice_stage

Overview:
- Keccak rho step, placed directly downstream of the column-parity (theta) datapath.
- Accepts the 1600-bit state as Count slices of 25 bits, in slice order 0..Count-1, and buffers the whole state.
- Emits Count rotated slices in the same slice order, ready for the pi stage.
- Rotation rule: output lane bit (x,y) at slice z = input lane bit (x,y) at slice (z - r[x][y]) mod Count.

Parameters:
- Count, 64, lane width and number of slices; rho offsets are reduced mod Count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a new state transfer; sampled only in IDLE
- inValid  in  1  matrixIn holds a valid slice
- matrixIn  in  25  input slice; bit 5*y+x = lane (x,y)
- inReady  out  1  stage accepts a slice this cycle
- matrixOut  out  25  rotated output slice; same bit mapping as matrixIn
- outValid  out  1  matrixOut valid
- outReady  in  1  consumer takes matrixOut this cycle
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after the last output slice is taken

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset: state IDLE; inCnt and outCnt = 0; inReady, outValid, busy and done = 0; matrixOut = 0. Buffer contents are don't-care and are not cleared.
- States: IDLE, LOAD, EMIT, DONE.
- IDLE:
  - start=1 → LOAD; inCnt cleared.
  - Otherwise stay in IDLE.
- LOAD:
  - inReady=1.
  - Each cycle with inValid=1: buf[inCnt] <= matrixIn; inCnt++.
  - inValid=0 cycles are gaps: no write, no count.
  - Accepting slice Count-1 → EMIT next cycle; outCnt=0.
- EMIT:
  - outValid=1; inReady=0.
  - matrixOut[i] = buf[(outCnt - r[i]) mod Count][i], combinational from buffer and outCnt.
  - outReady=1: outCnt++.
  - outReady=0: outCnt and matrixOut hold stable.
  - Transfer at outCnt=Count-1 → DONE.
- DONE: done=1 for one cycle, then IDLE; busy=0 from IDLE onward.
- Latency: first output slice valid the cycle after the last input slice is accepted. Minimum total time is 2*Count+2 cycles from start to done.
- Index arithmetic: unsigned, CntBits=$clog2(Count) bits, wrap-around modulo Count. Subtraction must wrap, not saturate.
- Offsets, indexed r[x][y]:
  - x=0: 0,36,3,41,18
  - x=1: 1,44,10,45,2
  - x=2: 62,6,43,15,61
  - x=3: 28,55,25,21,56
  - x=4: 27,20,39,8,14
- start outside IDLE: ignored.
- inValid outside LOAD: ignored; no buffer write.
- outReady outside EMIT: ignored.
- Reset mid-LOAD or mid-EMIT: immediate return to IDLE with counters 0. No done pulse. The partial state is discarded, and a later start must reload all Count slices.
- start and rst together: rst wins.

Decomposition:
- Shared package keccak_pkg holds Count default, slice width 25, the rho offset table as a 25-entry constant (index 5*y+x), and the state encoding.
- Sub-module rho_slice_buffer: Count x 25 register file with one write port (slice index plus data) and 25 per-lane read addresses producing the rotated slice.
- Top level contains the FSM, the two counters and the handshake logic.

Test Plan:
1. Load only lane(1,0) bit at slice 0, all other bits 0 → output slice 1 = 25'h0000002; every other output slice = 0.
2. Lane(2,0) set at slice 5 (offset 62) → output slice 3 bit 2 set; checks wrap-around. Lane(0,0) all-ones → bit 0 set in all 64 output slices.
3. Random 1600-bit state with random inValid gaps → all 64 output slices match a reference rho model. done pulses once; busy drops on the same cycle done falls.
4. outReady driven 1,0,0,1 repeatedly during EMIT → matrixOut stable while outReady=0, no slice skipped or repeated, done only after the 64th transfer.
5. rst asserted after 30 slices loaded, then start and a full new state → output matches the new state only; no done pulse for the aborted run.
6. start pulsed during LOAD and EMIT, inValid high during EMIT → no state change, buffer uncorrupted, output still correct.
